nonce_scheduler: RTL and testbench

//   Sequences a bank of NCORE lockstep SHA cores through the 32-bit nonce space for one mining job.

---
 rtl/nonce_sched_pkg.sv | 14 +
 rtl/hit_prio_enc.sv | 22 ++
 rtl/nonce_scheduler.sv | 161 ++++++++++++++++
 tb/tb_nonce_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_sched_pkg.sv
// rtl/nonce_sched_pkg.sv - shared types and constants for the nonce scheduler
package nonce_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HASH   = 2'd1,
        CHECK  = 2'd2,
        REPORT = 2'd3
    } sched_state_t;

    localparam logic [31:0] NONCE_MAX      = 32'hFFFF_FFFF;
    localparam int          ROUNDS_DEFAULT = 64;

endpackage

// File: rtl/hit_prio_enc.sv
// rtl/hit_prio_enc.sv - combinational lowest-index priority encoder for core hit flags
module hit_prio_enc #(
    parameter int NCORE = 1,
    parameter int IW    = (NCORE > 1) ? $clog2(NCORE) : 1
) (
    input  logic [NCORE-1:0] hit_i,
    output logic             any_hit_o,
    output logic [IW-1:0]    idx_o
);

    always_comb begin
        any_hit_o = |hit_i;
        idx_o     = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = NCORE - 1; i >= 0; i--) begin
            if (hit_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/nonce_scheduler.sv
// rtl/nonce_scheduler.sv - batches lockstep SHA cores through one job's nonce space
// Optional NONCE_STATS_EN adds saturating batch/hit counters.
module nonce_scheduler
    import nonce_sched_pkg::*;
#(
    parameter int NCORE  = 1,
    parameter int ROUNDS = ROUNDS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    input  logic [31:0]      job_nonce,
    output logic             job_ready,
    input  logic             job_abort,
    output logic             core_start,
    output logic [5:0]       cycle,
    output logic [31:0]      nonce_base,
    input  logic [NCORE-1:0] core_hit,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_found,
    output logic [31:0]      res_nonce,
    output logic             busy
`ifdef NONCE_STATS_EN
    ,
    output logic [31:0]      stat_batches,
    output logic [31:0]      stat_hits
`endif
);

    localparam int          IW         = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam logic [5:0]  LAST_CYCLE = 6'(ROUNDS - 1);

    sched_state_t      state_q;
    logic [5:0]        cycle_q;
    logic [31:0]       base_q;
    logic              core_start_q;
    logic              res_valid_q;
    logic              res_found_q;
    logic [31:0]       res_nonce_q;

    logic [NCORE-1:0]  valid_mask;
    logic [NCORE-1:0]  masked_hit;
    logic              any_hit;
    logic [IW-1:0]     hit_idx;
    logic              exhausted;

    // A core is only valid if its nonce fits in 32 bits; the space never wraps.
    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < NCORE; i++) begin
            valid_mask[i] = ({1'b0, base_q} + 33'(i)) <= {1'b0, NONCE_MAX};
        end
    end

    assign masked_hit = core_hit & valid_mask;
    assign exhausted  = ({1'b0, base_q} + 33'(NCORE)) > {1'b0, NONCE_MAX};

    hit_prio_enc #(
        .NCORE (NCORE),
        .IW    (IW)
    ) u_hit_prio_enc (
        .hit_i     (masked_hit),
        .any_hit_o (any_hit),
        .idx_o     (hit_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cycle_q      <= '0;
            base_q       <= '0;
            core_start_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_found_q  <= 1'b0;
            res_nonce_q  <= '0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (job_valid) begin
                        base_q       <= job_nonce;
                        cycle_q      <= '0;
                        core_start_q <= 1'b1;
                        state_q      <= HASH;
                    end
                end
                HASH: begin
                    if (job_abort) begin
                        cycle_q <= '0;
                        state_q <= IDLE;
                    end else if (cycle_q == LAST_CYCLE) begin
                        cycle_q <= '0;
                        state_q <= CHECK;
                    end else begin
                        cycle_q <= cycle_q + 6'd1;
                    end
                end
                CHECK: begin
                    if (job_abort) begin
                        cycle_q <= '0;
                        state_q <= IDLE;
                    end else if (any_hit) begin
                        res_nonce_q <= base_q + 32'(hit_idx);
                        res_found_q <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= REPORT;
                    end else if (exhausted) begin
                        res_nonce_q <= '0;
                        res_found_q <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= REPORT;
                    end else begin
                        base_q       <= base_q + 32'(NCORE);
                        core_start_q <= 1'b1;
                        state_q      <= HASH;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef NONCE_STATS_EN
    logic [31:0] stat_batches_q;
    logic [31:0] stat_hits_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_batches_q <= '0;
            stat_hits_q    <= '0;
        end else if (state_q == CHECK) begin
            if (stat_batches_q != NONCE_MAX) begin
                stat_batches_q <= stat_batches_q + 32'd1;
            end
            if (!job_abort && any_hit && (stat_hits_q != NONCE_MAX)) begin
                stat_hits_q <= stat_hits_q + 32'd1;
            end
        end
    end

    assign stat_batches = stat_batches_q;
    assign stat_hits    = stat_hits_q;
`endif

    assign job_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign core_start = core_start_q;
    assign cycle      = cycle_q;
    assign nonce_base = base_q;
    assign res_valid  = res_valid_q;
    assign res_found  = res_found_q;
    assign res_nonce  = res_nonce_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// tb/tb_nonce_scheduler.sv - randomized self-checking bench for nonce_scheduler
module tb_nonce_scheduler;

    localparam int NC     = 4;
    localparam int ROUNDS = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_valid;
    logic [31:0]   job_nonce;
    logic          job_ready;
    logic          job_abort;
    logic          core_start;
    logic [5:0]    cycle;
    logic [31:0]   nonce_base;
    logic [NC-1:0] core_hit;
    logic          res_valid;
    logic          res_ready;
    logic          res_found;
    logic [31:0]   res_nonce;
    logic          busy;
`ifdef NONCE_STATS_EN
    logic [31:0]   stat_batches;
    logic [31:0]   stat_hits;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nonce_scheduler #(
        .NCORE  (NC),
        .ROUNDS (ROUNDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_nonce  (job_nonce),
        .job_ready  (job_ready),
        .job_abort  (job_abort),
        .core_start (core_start),
        .cycle      (cycle),
        .nonce_base (nonce_base),
        .core_hit   (core_hit),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_found  (res_found),
        .res_nonce  (res_nonce),
        .busy       (busy)
`ifdef NONCE_STATS_EN
        ,
        .stat_batches (stat_batches),
        .stat_hits    (stat_hits)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Batch outcome from the nonce-space rules: 0 = next batch, 1 = found, 2 = exhausted.
    function automatic int decide(input logic [31:0] base, input logic [NC-1:0] hv,
                                  output logic [31:0] nonce);
        logic [63:0] b;
        b     = {32'd0, base};
        nonce = 32'd0;
        for (int i = 0; i < NC; i++) begin
            if (hv[i] && (b + 64'(i) <= 64'hFFFF_FFFF)) begin
                nonce = 32'(b + 64'(i));
                return 1;
            end
        end
        if (b + 64'(NC) > 64'hFFFF_FFFF) return 2;
        return 0;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_job_ready"}, 64'(job_ready), 64'd1);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_cycle"},     64'(cycle),     64'd0);
    endtask

    task automatic run_job(input logic [31:0] start, input int hit_batch,
                           input logic [NC-1:0] hit_vec, input int abort_batch, input int hold);
        logic [31:0]   base;
        logic [31:0]   exp_nonce;
        logic [NC-1:0] hv;
        int            batch;
        int            k;
        int            res;
        int            budget;
        logic          done;
        logic          step;

        @(negedge clk);
        job_nonce = start;
        job_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        base      = start;
        batch     = 0;
        k         = 0;
        res       = 0;
        exp_nonce = 32'd0;
        budget    = 0;
        done      = 1'b0;
        while (!done && budget < 3000) begin
            step = 1'b1;
            if (k < ROUNDS) begin
                check("hash_cycle",      64'(cycle),      64'(k));
                check("hash_core_start", 64'(core_start), 64'(k == 0));
                check("hash_base",       64'(nonce_base), 64'(base));
                check("hash_busy",       64'(busy),       64'd1);
                check("hash_job_ready",  64'(job_ready),  64'd0);
                check("hash_res_valid",  64'(res_valid),  64'd0);
                core_hit  = NC'($urandom);
                job_abort = 1'b0;
                job_valid = 1'($urandom);
                job_nonce = $urandom;
            end else if (k == ROUNDS) begin
                check("chk_cycle",      64'(cycle),      64'd0);
                check("chk_core_start", 64'(core_start), 64'd0);
                check("chk_base",       64'(nonce_base), 64'(base));
                hv        = (batch == hit_batch) ? hit_vec : '0;
                core_hit  = hv;
                job_abort = (batch == abort_batch);
                job_valid = 1'b0;
                res       = decide(base, hv, exp_nonce);
            end else begin
                job_abort = 1'b0;
                core_hit  = NC'($urandom);
                if (batch == abort_batch) begin
                    check_idle("abort");
                    done = 1'b1;
                end else if (res == 0) begin
                    base  = base + 32'(NC);
                    batch = batch + 1;
                    k     = 0;
                    step  = 1'b0;
                end else begin
                    for (int h = 0; h <= hold; h++) begin
                        check("rep_valid", 64'(res_valid), 64'd1);
                        check("rep_found", 64'(res_found), 64'(res == 1));
                        check("rep_nonce", 64'(res_nonce), 64'(exp_nonce));
                        check("rep_base",  64'(nonce_base), 64'(base));
                        check("rep_busy",  64'(busy),      64'd1);
                        check("rep_ready", 64'(job_ready), 64'd0);
                        if (h < hold) begin
                            res_ready = 1'b0;
                            job_abort = 1'($urandom);
                            core_hit  = NC'($urandom);
                            @(posedge clk);
                            @(negedge clk);
                        end
                    end
                    job_abort = 1'b0;
                    res_ready = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    res_ready = 1'b0;
                    check_idle("post_report");
                    done = 1'b1;
                end
            end
            if (!done && step) begin
                @(posedge clk);
                @(negedge clk);
                k++;
                budget++;
            end
        end
        check("job_completed", 64'(done), 64'd1);
        job_valid = 1'b0;
        job_abort = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        job_valid = 1'b0;
        job_nonce = 32'd0;
        job_abort = 1'b0;
        core_hit  = '0;
        res_ready = 1'b0;
        #2;
        check_idle("reset");
        check("reset_base",       64'(nonce_base), 64'd0);
        check("reset_core_start", 64'(core_start), 64'd0);
        check("reset_res_found",  64'(res_found),  64'd0);
        check("reset_res_nonce",  64'(res_nonce),  64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_job(32'h0000_0100, 2, 4'b0100, -1, 0);
        run_job(32'hFFFF_FFF8, -1, 4'b0000, -1, 0);
        run_job(32'hFFFF_FFFE, 0, 4'b1100, -1, 1);
        run_job(32'hFFFF_FFFE, 0, 4'b1110, -1, 0);
        run_job(32'h0000_0020, 0, 4'b1010, -1, 10);
        run_job(32'h0000_0040, 1, 4'b0001, 1, 0);

        // Asynchronous reset in the middle of a batch.
        @(negedge clk);
        job_nonce = 32'h0000_0500;
        job_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        job_valid = 1'b0;
        repeat (37) @(posedge clk);
        #2;
        check("pre_rst_cycle", 64'(cycle), 64'd37);
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        check("async_rst_base",       64'(nonce_base), 64'd0);
        check("async_rst_core_start", 64'(core_start), 64'd0);
        check("async_rst_res_nonce",  64'(res_nonce),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_job(32'h0000_0600, 0, 4'b1000, -1, 0);

        for (int j = 0; j < 20; j++) begin
            logic [31:0] st;
            st = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 20))) : $urandom;
            run_job(st, int'($urandom_range(0, 3)), NC'($urandom),
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1,
                    int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
